// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port register file.
package regfile_pkg;

  typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} rf_state_e;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_NREGS = 32;
  localparam int DEF_NRD   = 2;

  function automatic int reg_aw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_clr_fsm.sv
// Sequential clear engine: sweeps zeros through the array after reset or on
// request, and latches a sticky error for writes attempted while sweeping.
module regfile_clr_fsm
  import regfile_pkg::*;
#(
  parameter int NREGS = DEF_NREGS,
  parameter int AW    = reg_aw(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_req,
  input  logic          we,
  output logic          busy,
  output logic          wr_err,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  rf_state_e     state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          wr_err_q, wr_err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_CLEAR;
      ptr_q    <= '0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      wr_err_q <= wr_err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    wr_err_d = wr_err_q | (we & (state_q == ST_CLEAR));
    case (state_q)
      ST_CLEAR: begin
        // A new request mid-sweep starts over so every entry is cleared after it.
        if (clr_req) begin
          ptr_d = '0;
        end else if (ptr_q == LAST) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  assign busy     = (state_q == ST_CLEAR);
  assign clr_we   = busy;
  assign clr_addr = ptr_q;
  assign wr_err   = wr_err_q;

endmodule

// File: rtl/regfile_mp.sv
// Parameterised multi-read-port register file with a sequential clear engine.
// Optional same-cycle write forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = DEF_XLEN,
  parameter int NREGS    = DEF_NREGS,
  parameter int NRD      = DEF_NRD,
  parameter int ZERO_REG = 1,
  localparam int AW      = reg_aw(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_req,
  output logic                busy,
  output logic                wr_err,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [XLEN-1:0]     wdata,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata
);

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic            clr_we;
  logic [AW-1:0]   clr_addr;
  logic            arr_we;
  logic [AW-1:0]   arr_addr;
  logic [XLEN-1:0] arr_wdata;
  logic            wr_zero;
  logic            fwd_en;

  logic [XLEN-1:0] mem_q [NREGS];

  regfile_clr_fsm #(.NREGS(NREGS), .AW(AW)) u_clr (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .we       (we),
    .busy     (busy),
    .wr_err   (wr_err),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign wr_zero = (ZERO_REG != 0) && (waddr == '0);

  // The clear engine owns the write port whenever it is sweeping.
  always_comb begin
    arr_we    = 1'b0;
    arr_addr  = waddr;
    arr_wdata = wdata;
    if (clr_we) begin
      arr_we    = 1'b1;
      arr_addr  = clr_addr;
      arr_wdata = '0;
    end else if (we && !clr_req && !wr_zero) begin
      arr_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (arr_we) mem_q[arr_addr] <= arr_wdata;
  end

  assign fwd_en = BYPASS && we && !busy && !clr_req && !wr_zero;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rd;
    always_comb begin
      ra = raddr[k*AW +: AW];
      rd = mem_q[ra];
      if (fwd_en && (ra == waddr)) rd = wdata;
      if (busy || ((ZERO_REG != 0) && (ra == '0))) rd = '0;
    end
    assign rdata[k*XLEN +: XLEN] = rd;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed scoreboard bench for regfile_mp (default parameters).
module tb_regfile_mp;
  localparam int XLEN = 32, NREGS = 32, NRD = 2, AW = 5;

  logic                clk = 1'b0;
  logic                rst, clr_req, we;
  logic                busy, wr_err;
  logic [AW-1:0]       waddr;
  logic [XLEN-1:0]     wdata;
  logic [NRD*AW-1:0]   raddr;
  logic [NRD*XLEN-1:0] rdata;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q [$];
  string       tag_q [$];

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy), .wr_err(wr_err),
    .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr), .rdata(rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic observe(input logic [31:0] obs);
    logic [31:0] e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (obs === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", t, obs, e);
    end
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    raddr = {a1, a0};
  endtask

  function automatic logic [31:0] rd0();
    return rdata[0 +: XLEN];
  endfunction
  function automatic logic [31:0] rd1();
    return rdata[XLEN +: XLEN];
  endfunction

  // Counts rising edges until busy falls; bounded so a stuck engine still reports.
  task automatic count_busy(input string tag, input int want);
    int n = 0;
    expect_val(tag, 32'(want));
    do begin
      tick();
      n++;
    end while (busy && n < 200);
    observe(32'(n));
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    expect_val(tag, 32'd0);
    observe({31'd0, busy});
  endtask

  initial begin
    rst = 1'b1; clr_req = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr = '0;
    repeat (3) tick();
    set_rd(5'd3, 5'd17);
    #1;
    expect_val("rst_busy", 32'd1);   observe({31'd0, busy});
    expect_val("rst_wr_err", 32'd0); observe({31'd0, wr_err});
    expect_val("rst_rdata0", 32'd0); observe(rd0());
    expect_val("rst_rdata1", 32'd0); observe(rd1());

    rst = 1'b0;
    count_busy("reset_sweep_len", NREGS);

    for (int a = 0; a < NREGS; a += 2) begin
      set_rd(AW'(a), AW'(a + 1));
      #1;
      expect_val($sformatf("sweep_zero_%0d", a), 32'd0);     observe(rd0());
      expect_val($sformatf("sweep_zero_%0d", a + 1), 32'd0); observe(rd1());
    end

    tick();
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; set_rd(5'd5, 5'd5);
    #1;
`ifdef REGFILE_BYPASS_EN
    expect_val("wr5_same_cycle", 32'hDEADBEEF);
`else
    expect_val("wr5_same_cycle", 32'h0);
`endif
    observe(rd0());
    tick();
    we = 1'b0;
    #1;
    expect_val("rd5_port0", 32'hDEADBEEF); observe(rd0());
    expect_val("rd5_port1", 32'hDEADBEEF); observe(rd1());

    we = 1'b1; waddr = 5'd0; wdata = 32'h1234; set_rd(5'd0, 5'd5);
    #1;
    expect_val("zero_bypass", 32'd0); observe(rd0());
    tick();
    we = 1'b0;
    #1;
    expect_val("zero_read", 32'd0);   observe(rd0());
    expect_val("zero_wr_err", 32'd0); observe({31'd0, wr_err});

    we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5; set_rd(5'd7, 5'd5);
    #1;
`ifdef REGFILE_BYPASS_EN
    expect_val("byp7_now", 32'hA5A5A5A5);
`else
    expect_val("byp7_now", 32'h0);
`endif
    observe(rd0());
    expect_val("byp_other_port", 32'hDEADBEEF); observe(rd1());
    tick();
    we = 1'b0;
    #1;
    expect_val("byp7_next", 32'hA5A5A5A5); observe(rd0());

    // clr_req with we together: clear wins, no error flagged.
    clr_req = 1'b1; we = 1'b1; waddr = 5'd9; wdata = 32'h99;
    tick();
    clr_req = 1'b0; we = 1'b0;
    #1;
    expect_val("clr_we_busy", 32'd1);   observe({31'd0, busy});
    expect_val("clr_we_noerr", 32'd0);  observe({31'd0, wr_err});
    set_rd(5'd7, 5'd5);
    #1;
    expect_val("busy_rdata0", 32'd0); observe(rd0());
    wait_idle("clr1_done");
    #1;
    expect_val("after_clr_7", 32'd0); observe(rd0());
    expect_val("after_clr_5", 32'd0); observe(rd1());

    // Write during clear: once early (addr 3), once after the sweep passed addr 2.
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    tick();
    we = 1'b1; waddr = 5'd3; wdata = 32'hFF;
    tick();
    we = 1'b0;
    #1;
    expect_val("wr_busy_err", 32'd1); observe({31'd0, wr_err});
    repeat (8) tick();
    we = 1'b1; waddr = 5'd2; wdata = 32'hFF;
    tick();
    we = 1'b0;
    wait_idle("clr2_done");
    set_rd(5'd3, 5'd2);
    #1;
    expect_val("wr_busy_drop3", 32'd0); observe(rd0());
    expect_val("wr_busy_drop2", 32'd0); observe(rd1());
    expect_val("wr_err_sticky", 32'd1); observe({31'd0, wr_err});

    // Restart: second request in the tenth busy cycle.
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    begin
      int n = 0;
      expect_val("restart_len", 32'd42);
      while (busy && n < 200) begin
        n++;
        clr_req = (n == 10);
        tick();
      end
      clr_req = 1'b0;
      observe(32'(n));
    end

    // Reset in the middle of a sweep (ptr = 20).
    tick();
    we = 1'b1; waddr = 5'd11; wdata = 32'h5A5A;
    tick();
    we = 1'b0;
    set_rd(5'd11, 5'd0);
    #1;
    expect_val("pre_rst_data", 32'h5A5A); observe(rd0());
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (20) tick();
    rst = 1'b1;
    #1;
    expect_val("midrst_busy", 32'd1);   observe({31'd0, busy});
    expect_val("midrst_wr_err", 32'd0); observe({31'd0, wr_err});
    tick();
    rst = 1'b0;
    count_busy("midrst_sweep_len", NREGS);
    #1;
    expect_val("midrst_clear_11", 32'd0); observe(rd0());
    expect_val("midrst_err_low", 32'd0);  observe({31'd0, wr_err});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parameterised multi-read-port register file for the processor datapath, sitting between decode (read addresses) and writeback (write port). It generalises the existing 32x32 two-read file to configurable width, depth and read-port count. It replaces the flop-wide asynchronous clear with a sequential clear engine, so the array can map to memory. It optionally hardwires entry 0 and forwards same-cycle writes to readers.

## Interface
Parameters:
- XLEN, 32, data width in bits
- NREGS, 32, number of entries; power of two, at least 2
- NRD, 2, number of read ports, at least 1
- ZERO_REG, 1, when 1 entry 0 always reads 0 and ignores writes

Ports (AW = $clog2(NREGS)):
- clk  in  1  clock
- rst  in  1  reset rst, asynchronous, active-high
- clr_req  in  1  request a full clear of the array
- busy  out  1  clear engine active; port is unavailable
- wr_err  out  1  sticky flag; a write was attempted while busy
- we  in  1  write enable
- waddr  in  AW  write address
- wdata  in  XLEN  write data
- raddr  in  NRD*AW  read addresses; port k uses bits [k*AW +: AW]
- rdata  out  NRD*XLEN  read data; port k uses bits [k*XLEN +: XLEN]

## Operation
- FSM states: CLEAR and IDLE. rst forces CLEAR with ptr=0. The array itself has no reset.
- CLEAR:
  - Each cycle writes 0 to entry ptr, then ptr increments.
  - When ptr==NREGS-1 is written, the next state is IDLE.
  - clr_req during CLEAR restarts ptr at 0.
- IDLE:
  - clr_req moves the FSM to CLEAR with ptr=0 on the next edge.
  - When we=1 and clr_req=0, wdata is written to waddr at the edge.
  - When clr_req=1 and we=1 arrive together, the clear takes priority and the write is dropped. wr_err is not set in this case.
- busy is 1 in CLEAR and 0 in IDLE.
- Writes while busy:
  - we=1 while busy drops the write and sets wr_err on the edge.
  - wr_err clears only on rst.
- Reads:
  - Reads are combinational from the array.
  - While busy, every rdata port reads 0.
- ZERO_REG=1:
  - Writes to address 0 are discarded without error.
  - Reads of address 0 return 0 regardless of the array contents or bypass.
- Read ports are independent, so any number of ports may read the same address.

## Timing
- Reset values: busy=1, wr_err=0, rdata=0, state=CLEAR, ptr=0.
- After rst deasserts, busy stays high for exactly NREGS rising edges. The first write is accepted on the edge after busy falls.
- clr_req sampled in IDLE gives busy=1 from the next cycle, for NREGS cycles.
- rst asserted mid-clear or mid-write takes effect immediately: state returns to CLEAR, ptr=0, and a full sweep restarts.
- Write-to-read latency without bypass is 1 cycle: the new value is visible in the cycle after the write edge.
- ptr is AW bits wide and never wraps past NREGS-1.

## Configuration
- The macro REGFILE_BYPASS_EN controls same-cycle write forwarding.
- Defined:
  - A read port whose raddr equals waddr gets wdata combinationally when we=1, busy=0 and clr_req=0.
  - With ZERO_REG=1, address 0 is excluded from forwarding.
- Undefined:
  - That read port returns the old array value.
  - The new value is visible in the next cycle.

## Structure
- Shared package regfile_pkg holds:
  - the FSM state enum (ST_IDLE, ST_CLEAR)
  - the default XLEN/NREGS/NRD constants
  - an address-width helper function
- Sub-module regfile_clr_fsm contains the state register, ptr counter and wr_err logic. It outputs busy, clr_we and clr_addr.
- The top level contains:
  - the array
  - write-port muxing (the clear engine has priority over the external write)
  - the generate loop of read ports with zero, busy and bypass gating.

## Test plan
- Reset sweep: assert rst, release, count edges → busy=1 for exactly 32 cycles, then 0. Every address reads 0 after the sweep.
- Write/read: write 0xDEADBEEF to address 5, then read 5 on ports 0 and 1 next cycle → both return 0xDEADBEEF. Address 0 written with 0x1234 still reads 0.
- Bypass:
  - Same-cycle we=1, waddr=7, wdata=0xA5A5A5A5, raddr0=7.
  - With REGFILE_BYPASS_EN: rdata0=0xA5A5A5A5 that cycle.
  - Without it: the old value that cycle, 0xA5A5A5A5 the next.
- Write during clear: pulse clr_req, then we=1 to address 3 with 0xFF two cycles later → write dropped, wr_err=1 and remains 1. Address 3 reads 0 after the clear.
- Clear restart: pulse clr_req, and again 10 cycles into the clear → busy stays high 10+32 cycles in total.
- Mid-clear reset: assert rst during a clear at ptr=20 → busy remains high for 32 full cycles after release. wr_err returns to 0.
